// File: rtl/lockstep_pkg.sv
// Shared definitions for the dual-core lockstep checker.
// Holds the checker FSM state encoding and the bit positions of the
// per-signal mismatch vector so injection benches can target single bits.
package lockstep_pkg;

  localparam int MIS_INSTR_REQ  = 0;
  localparam int MIS_INSTR_ADDR = 1;
  localparam int MIS_DATA_REQ   = 2;
  localparam int MIS_DATA_WE    = 3;
  localparam int MIS_DATA_BE    = 4;
  localparam int MIS_DATA_ADDR  = 5;
  localparam int MIS_DATA_WDATA = 6;
  localparam int MIS_CORE_BUSY  = 7;
  localparam int MIS_W          = 8;

  localparam int THRESH_MAX     = 15;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_ALARM   = 2'd2
  } lock_state_e;

endpackage

// File: rtl/lockstep_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   i_inc     : increment request (ignored once all-ones)
//   i_clr     : clear to zero, wins over i_inc
//   o_cnt     : current count
module lockstep_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/lockstep_checker.sv
// Lockstep checker: compares the bus activity of two redundant cores each
// cycle, debounces mismatches over THRESH consecutive compare cycles and
// raises a sticky alarm. Short episodes that self-clear are counted.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   enable_i              : compare enable (0 freezes checking)
//   clr_i                 : pulse clearing alarm and all status
//   *_cls1_i / *_cls2_i   : core 1 / core 2 bus signals
//   mismatch_o            : OR of the registered mismatch vector
//   suspect_o, alarm_o    : FSM status
//   fault_vec_o           : mismatch vector at start of current episode
//   transient_cnt_o       : saturating count of self-cleared episodes
//
// state   | meaning
// RUN     | cores agree, no open episode
// SUSPECT | episode open, fewer than THRESH consecutive mismatches seen
// ALARM   | lockstep failure, held until clr_i
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int THRESH = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             clr_i,
  input  logic             instr_req_cls1_i,
  input  logic             instr_req_cls2_i,
  input  logic [31:0]      instr_addr_cls1_i,
  input  logic [31:0]      instr_addr_cls2_i,
  input  logic             data_req_cls1_i,
  input  logic             data_req_cls2_i,
  input  logic             data_we_cls1_i,
  input  logic             data_we_cls2_i,
  input  logic [3:0]       data_be_cls1_i,
  input  logic [3:0]       data_be_cls2_i,
  input  logic [31:0]      data_addr_cls1_i,
  input  logic [31:0]      data_addr_cls2_i,
  input  logic [31:0]      data_wdata_cls1_i,
  input  logic [31:0]      data_wdata_cls2_i,
  input  logic             core_busy_cls1_i,
  input  logic             core_busy_cls2_i,
  output logic             mismatch_o,
  output logic             suspect_o,
  output logic             alarm_o,
  output logic [7:0]       fault_vec_o,
  output logic [CNT_W-1:0] transient_cnt_o
);

  localparam logic [3:0] C_THRESH = 4'(THRESH);

  logic             w_any_ireq;
  logic             w_any_dreq;
  logic             w_any_we;
  logic [MIS_W-1:0] w_mis_raw;

  logic [MIS_W-1:0] r_mis_q;
  logic             r_mismatch;
  lock_state_e      r_state;
  logic [3:0]       r_cnt;
  logic [MIS_W-1:0] r_fault;
  logic             r_suspect;
  logic             r_alarm;

  lock_state_e      w_state_d;
  logic [3:0]       w_cnt_d;
  logic [MIS_W-1:0] w_fault_d;
  logic             w_tr_inc;

  assign w_any_ireq = instr_req_cls1_i | instr_req_cls2_i;
  assign w_any_dreq = data_req_cls1_i | data_req_cls2_i;
  assign w_any_we   = data_we_cls1_i | data_we_cls2_i;

  // Address/data fields only matter while a core is actually issuing a
  // request; otherwise their values are don't-care on the bus.
  always_comb begin
    w_mis_raw                 = '0;
    w_mis_raw[MIS_INSTR_REQ]  = instr_req_cls1_i ^ instr_req_cls2_i;
    w_mis_raw[MIS_INSTR_ADDR] = w_any_ireq && (instr_addr_cls1_i != instr_addr_cls2_i);
    w_mis_raw[MIS_DATA_REQ]   = data_req_cls1_i ^ data_req_cls2_i;
    w_mis_raw[MIS_DATA_WE]    = w_any_dreq && (data_we_cls1_i != data_we_cls2_i);
    w_mis_raw[MIS_DATA_BE]    = w_any_dreq && (data_be_cls1_i != data_be_cls2_i);
    w_mis_raw[MIS_DATA_ADDR]  = w_any_dreq && (data_addr_cls1_i != data_addr_cls2_i);
    w_mis_raw[MIS_DATA_WDATA] = w_any_dreq && w_any_we &&
                                (data_wdata_cls1_i != data_wdata_cls2_i);
    w_mis_raw[MIS_CORE_BUSY]  = core_busy_cls1_i ^ core_busy_cls2_i;
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_fault_d = r_fault;
    w_tr_inc  = 1'b0;
    if (clr_i) begin
      w_state_d = ST_RUN;
      w_cnt_d   = '0;
      w_fault_d = '0;
    end else if (enable_i) begin
      unique case (r_state)
        ST_RUN: begin
          if (r_mis_q != '0) begin
            w_fault_d = r_mis_q;
            w_cnt_d   = 4'd1;
            w_state_d = (C_THRESH == 4'd1) ? ST_ALARM : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (r_mis_q != '0) begin
            w_cnt_d = r_cnt + 4'd1;
            if ((r_cnt + 4'd1) == C_THRESH) begin
              w_state_d = ST_ALARM;
            end
          end else begin
            w_cnt_d   = '0;
            w_state_d = ST_RUN;
            w_tr_inc  = 1'b1;
          end
        end
        ST_ALARM: begin
          w_state_d = ST_ALARM;
        end
        default: begin
          w_state_d = ST_RUN;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis_q    <= '0;
      r_mismatch <= 1'b0;
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_fault    <= '0;
      r_suspect  <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_mis_q    <= enable_i ? w_mis_raw : '0;
      r_mismatch <= enable_i && (w_mis_raw != '0);
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_fault    <= w_fault_d;
      // Status flags are registered copies of the next state so the outputs
      // come straight from flops.
      r_suspect  <= (w_state_d == ST_SUSPECT);
      r_alarm    <= (w_state_d == ST_ALARM);
    end
  end

  lockstep_sat_cnt #(
    .W (CNT_W)
  ) u_transient_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_tr_inc),
    .i_clr (clr_i),
    .o_cnt (transient_cnt_o)
  );

  assign mismatch_o  = r_mismatch;
  assign suspect_o   = r_suspect;
  assign alarm_o     = r_alarm;
  assign fault_vec_o = r_fault;

endmodule

// File: tb/tb_lockstep_checker.sv
module tb_lockstep_checker;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable_i;
  logic             clr_i;
  logic             instr_req_cls1_i, instr_req_cls2_i;
  logic [31:0]      instr_addr_cls1_i, instr_addr_cls2_i;
  logic             data_req_cls1_i, data_req_cls2_i;
  logic             data_we_cls1_i, data_we_cls2_i;
  logic [3:0]       data_be_cls1_i, data_be_cls2_i;
  logic [31:0]      data_addr_cls1_i, data_addr_cls2_i;
  logic [31:0]      data_wdata_cls1_i, data_wdata_cls2_i;
  logic             core_busy_cls1_i, core_busy_cls2_i;
  logic             mismatch_o;
  logic             suspect_o;
  logic             alarm_o;
  logic [7:0]       fault_vec_o;
  logic [CNT_W-1:0] transient_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lockstep_checker #(
    .THRESH (2),
    .CNT_W  (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable_i          (enable_i),
    .clr_i             (clr_i),
    .instr_req_cls1_i  (instr_req_cls1_i),
    .instr_req_cls2_i  (instr_req_cls2_i),
    .instr_addr_cls1_i (instr_addr_cls1_i),
    .instr_addr_cls2_i (instr_addr_cls2_i),
    .data_req_cls1_i   (data_req_cls1_i),
    .data_req_cls2_i   (data_req_cls2_i),
    .data_we_cls1_i    (data_we_cls1_i),
    .data_we_cls2_i    (data_we_cls2_i),
    .data_be_cls1_i    (data_be_cls1_i),
    .data_be_cls2_i    (data_be_cls2_i),
    .data_addr_cls1_i  (data_addr_cls1_i),
    .data_addr_cls2_i  (data_addr_cls2_i),
    .data_wdata_cls1_i (data_wdata_cls1_i),
    .data_wdata_cls2_i (data_wdata_cls2_i),
    .core_busy_cls1_i  (core_busy_cls1_i),
    .core_busy_cls2_i  (core_busy_cls2_i),
    .mismatch_o        (mismatch_o),
    .suspect_o         (suspect_o),
    .alarm_o           (alarm_o),
    .fault_vec_o       (fault_vec_o),
    .transient_cnt_o   (transient_cnt_o)
  );

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_same();
    instr_req_cls1_i  = 1'b1;          instr_req_cls2_i  = 1'b1;
    instr_addr_cls1_i = 32'h0000_1000; instr_addr_cls2_i = 32'h0000_1000;
    data_req_cls1_i   = 1'b1;          data_req_cls2_i   = 1'b1;
    data_we_cls1_i    = 1'b1;          data_we_cls2_i    = 1'b1;
    data_be_cls1_i    = 4'hF;          data_be_cls2_i    = 4'hF;
    data_addr_cls1_i  = 32'h2000_0080; data_addr_cls2_i  = 32'h2000_0080;
    data_wdata_cls1_i = 32'hDEAD_BEEF; data_wdata_cls2_i = 32'hDEAD_BEEF;
    core_busy_cls1_i  = 1'b1;          core_busy_cls2_i  = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_i = 1'b0; enable_i = 1'b1;
    set_same();
    step(3);
    rst = 1'b0;
    step(1);
    tests_run++;
    if ({mismatch_o, suspect_o, alarm_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b want 000", {mismatch_o, suspect_o, alarm_o});
    end
    tests_run++;
    if (fault_vec_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_fault got %h want 00", fault_vec_o);
    end
    tests_run++;
    if (transient_cnt_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_tcnt got %0d want 0", transient_cnt_o);
    end
  endtask

  task automatic test_identical();
    int bad_mis = 0, bad_alm = 0, bad_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      instr_req_cls1_i  = 1'($urandom);  instr_req_cls2_i  = instr_req_cls1_i;
      instr_addr_cls1_i = $urandom;      instr_addr_cls2_i = instr_addr_cls1_i;
      data_req_cls1_i   = 1'($urandom);  data_req_cls2_i   = data_req_cls1_i;
      data_we_cls1_i    = 1'($urandom);  data_we_cls2_i    = data_we_cls1_i;
      data_be_cls1_i    = 4'($urandom);  data_be_cls2_i    = data_be_cls1_i;
      data_addr_cls1_i  = $urandom;      data_addr_cls2_i  = data_addr_cls1_i;
      data_wdata_cls1_i = $urandom;      data_wdata_cls2_i = data_wdata_cls1_i;
      core_busy_cls1_i  = 1'($urandom);  core_busy_cls2_i  = core_busy_cls1_i;
      step(1);
      if (mismatch_o !== 1'b0) bad_mis++;
      if (alarm_o !== 1'b0) bad_alm++;
      if (transient_cnt_o !== 4'd0) bad_cnt++;
    end
    set_same();
    step(2);
    tests_run++;
    if (bad_mis != 0) begin
      tests_failed++;
      $display("FAIL identical_mismatch got %0d bad cycles want 0", bad_mis);
    end
    tests_run++;
    if (bad_alm != 0) begin
      tests_failed++;
      $display("FAIL identical_alarm got %0d bad cycles want 0", bad_alm);
    end
    tests_run++;
    if (bad_cnt != 0) begin
      tests_failed++;
      $display("FAIL identical_tcnt got %0d bad cycles want 0", bad_cnt);
    end
  endtask

  task automatic test_glitch();
    set_same();
    data_addr_cls1_i[7] = ~data_addr_cls1_i[7];
    step(1);
    data_addr_cls1_i = data_addr_cls2_i;
    tests_run++;
    if (mismatch_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_mismatch got %b want 1", mismatch_o);
    end
    step(1);
    tests_run++;
    if ({suspect_o, alarm_o, fault_vec_o} !== {2'b10, 8'h20}) begin
      tests_failed++;
      $display("FAIL glitch_suspect got s=%b a=%b fv=%h want s=1 a=0 fv=20",
               suspect_o, alarm_o, fault_vec_o);
    end
    step(1);
    tests_run++;
    if ({suspect_o, alarm_o, transient_cnt_o} !== {2'b00, 4'd1}) begin
      tests_failed++;
      $display("FAIL glitch_return got s=%b a=%b tc=%0d want s=0 a=0 tc=1",
               suspect_o, alarm_o, transient_cnt_o);
    end
  endtask

  task automatic test_alarm();
    set_same();
    instr_req_cls1_i = 1'b0;
    step(2);
    instr_req_cls1_i = 1'b1;
    tests_run++;
    if ({suspect_o, alarm_o, fault_vec_o} !== {2'b10, 8'h01}) begin
      tests_failed++;
      $display("FAIL alarm_suspect got s=%b a=%b fv=%h want s=1 a=0 fv=01",
               suspect_o, alarm_o, fault_vec_o);
    end
    step(1);
    tests_run++;
    if ({suspect_o, alarm_o, fault_vec_o} !== {2'b01, 8'h01}) begin
      tests_failed++;
      $display("FAIL alarm_raise got s=%b a=%b fv=%h want s=0 a=1 fv=01",
               suspect_o, alarm_o, fault_vec_o);
    end
    data_be_cls2_i = 4'h3;
    step(4);
    data_be_cls2_i = 4'hF;
    step(2);
    tests_run++;
    if ({alarm_o, fault_vec_o} !== {1'b1, 8'h01}) begin
      tests_failed++;
      $display("FAIL alarm_held got a=%b fv=%h want a=1 fv=01", alarm_o, fault_vec_o);
    end
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    tests_run++;
    if ({mismatch_o, suspect_o, alarm_o, fault_vec_o, transient_cnt_o} !== 15'd0) begin
      tests_failed++;
      $display("FAIL alarm_clr got m=%b s=%b a=%b fv=%h tc=%0d want all 0",
               mismatch_o, suspect_o, alarm_o, fault_vec_o, transient_cnt_o);
    end
  endtask

  task automatic test_no_compare();
    int bad = 0;
    set_same();
    data_req_cls1_i = 1'b0; data_req_cls2_i = 1'b0;
    instr_req_cls1_i = 1'b0; instr_req_cls2_i = 1'b0;
    data_addr_cls2_i  = 32'h1234_5678;
    data_wdata_cls2_i = 32'h0;
    data_be_cls2_i    = 4'h1;
    data_we_cls2_i    = 1'b0;
    instr_addr_cls2_i = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (mismatch_o !== 1'b0 || suspect_o !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL no_compare got %0d flagged cycles want 0", bad);
    end
    // Read with both we low: wdata must be ignored even with req high.
    set_same();
    data_we_cls1_i = 1'b0; data_we_cls2_i = 1'b0;
    data_wdata_cls2_i = 32'h0;
    step(3);
    tests_run++;
    if ({mismatch_o, suspect_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL no_compare_read got m=%b s=%b want 00", mismatch_o, suspect_o);
    end
    set_same();
    step(1);
  endtask

  task automatic test_saturate();
    set_same();
    for (int k = 0; k < 16; k++) begin
      data_be_cls2_i[0] = 1'b0;
      step(1);
      data_be_cls2_i[0] = 1'b1;
      step(2);
      if (k == 14) begin
        tests_run++;
        if (transient_cnt_o !== 4'd15) begin
          tests_failed++;
          $display("FAIL sat_reach got %0d want 15", transient_cnt_o);
        end
      end
    end
    tests_run++;
    if ({transient_cnt_o, fault_vec_o} !== {4'd15, 8'h10}) begin
      tests_failed++;
      $display("FAIL sat_hold got tc=%0d fv=%h want tc=15 fv=10",
               transient_cnt_o, fault_vec_o);
    end
    pulse_clr();
  endtask

  task automatic test_clr_coincident();
    set_same();
    data_req_cls2_i = 1'b0;
    step(1);
    data_req_cls2_i = 1'b1;
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    tests_run++;
    if ({suspect_o, alarm_o, fault_vec_o} !== 10'd0) begin
      tests_failed++;
      $display("FAIL clr_coincident got s=%b a=%b fv=%h want 0 0 00",
               suspect_o, alarm_o, fault_vec_o);
    end
    step(2);
    tests_run++;
    if ({suspect_o, transient_cnt_o} !== 5'd0) begin
      tests_failed++;
      $display("FAIL clr_coincident_after got s=%b tc=%0d want 0 0",
               suspect_o, transient_cnt_o);
    end
  endtask

  task automatic test_enable_hold();
    set_same();
    core_busy_cls2_i = 1'b0;
    step(2);
    tests_run++;
    if (suspect_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL en_enter got s=%b want 1", suspect_o);
    end
    enable_i = 1'b0;
    step(4);
    tests_run++;
    if ({mismatch_o, suspect_o, alarm_o, fault_vec_o, transient_cnt_o} !==
        {3'b010, 8'h80, 4'd0}) begin
      tests_failed++;
      $display("FAIL en_hold got m=%b s=%b a=%b fv=%h tc=%0d want m=0 s=1 a=0 fv=80 tc=0",
               mismatch_o, suspect_o, alarm_o, fault_vec_o, transient_cnt_o);
    end
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    tests_run++;
    if ({suspect_o, fault_vec_o} !== 9'd0) begin
      tests_failed++;
      $display("FAIL en_clr got s=%b fv=%h want 0 00", suspect_o, fault_vec_o);
    end
    set_same();
    enable_i = 1'b1;
    step(2);
  endtask

  task automatic test_reset_midepisode();
    set_same();
    instr_addr_cls2_i = 32'h0000_1004;
    step(3);
    tests_run++;
    if (alarm_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_alarm got a=%b want 1", alarm_o);
    end
    rst = 1'b1; clr_i = 1'b1;
    step(1);
    rst = 1'b0; clr_i = 1'b0;
    set_same();
    tests_run++;
    if ({mismatch_o, suspect_o, alarm_o, fault_vec_o, transient_cnt_o} !== 15'd0) begin
      tests_failed++;
      $display("FAIL rst_alarm got m=%b s=%b a=%b fv=%h tc=%0d want all 0",
               mismatch_o, suspect_o, alarm_o, fault_vec_o, transient_cnt_o);
    end
    data_wdata_cls2_i = 32'h0;
    step(2);
    tests_run++;
    if (suspect_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_suspect got s=%b want 1", suspect_o);
    end
    rst = 1'b1;
    data_wdata_cls2_i = data_wdata_cls1_i;
    step(1);
    rst = 1'b0;
    step(3);
    tests_run++;
    if ({suspect_o, transient_cnt_o} !== 5'd0) begin
      tests_failed++;
      $display("FAIL rst_suspect got s=%b tc=%0d want 0 0", suspect_o, transient_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_identical();
    test_glitch();
    test_alarm();
    test_no_compare();
    test_saturate();
    test_clr_coincident();
    test_enable_hold();
    test_reset_midepisode();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
